// File: rtl/listener_fsm_pkg.sv
// Shared definitions for the req/ack handshake: FSM state encoding and the
// default synchroniser depth used on both sides of the crossing.
package listener_fsm_pkg;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StHold = 2'd1,
      StAck  = 2'd2
   } state_t;

   localparam int unsigned DEFAULT_SYNC_STAGES = 2;

endpackage

// File: rtl/sync_nff.sv
// N-stage single-bit synchroniser with synchronous active-high reset.
module sync_nff
   import listener_fsm_pkg::*;
#(
   parameter int unsigned STAGES = DEFAULT_SYNC_STAGES
) (
   input  logic clk,
   input  logic reset,
   input  logic i_d,
   output logic o_q
);

   logic [STAGES-1:0] r_sync;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_sync <= '0;
      end else begin
         r_sync <= {r_sync[STAGES-2:0], i_d};
      end
   end

   assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/listener_fsm.sv
// Receiving side of a 4-phase req/ack handshake: captures the talker's word,
// offers it to a valid/ready consumer and acknowledges only once it is taken.
module listener_fsm
   import listener_fsm_pkg::*;
#(
   parameter int unsigned DATA_WIDTH  = 8,
   parameter int unsigned SYNC_STAGES = DEFAULT_SYNC_STAGES,
   parameter int unsigned CNT_WIDTH   = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_in,
   input  logic [DATA_WIDTH-1:0] data_in,
   output logic                  ack_out,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  data_valid,
   input  logic                  data_ready,
   output logic                  busy,
   output logic [CNT_WIDTH-1:0]  xfer_count
);

   if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_stages
      $error("listener_fsm: SYNC_STAGES must be in 2..4");
   end

   state_t r_state;
   logic   w_req_s;

   sync_nff #(
      .STAGES (SYNC_STAGES)
   ) u_req_sync (
      .clk   (clk),
      .reset (reset),
      .i_d   (req_in),
      .o_q   (w_req_s)
   );

   // Outputs are assigned alongside each transition so they are pure flops.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= StIdle;
         ack_out    <= 1'b0;
         data_valid <= 1'b0;
         busy       <= 1'b0;
         data_out   <= '0;
         xfer_count <= '0;
      end else begin
         case (r_state)
            StIdle: begin
               if (w_req_s) begin
                  data_out   <= data_in;
                  data_valid <= 1'b1;
                  busy       <= 1'b1;
                  r_state    <= StHold;
               end
            end
            StHold: begin
               if (data_ready) begin
                  data_valid <= 1'b0;
                  ack_out    <= 1'b1;
                  r_state    <= StAck;
               end
            end
            StAck: begin
               if (!w_req_s) begin
                  ack_out    <= 1'b0;
                  busy       <= 1'b0;
                  xfer_count <= xfer_count + 1'b1;
                  r_state    <= StIdle;
               end
            end
            default: begin
               ack_out    <= 1'b0;
               data_valid <= 1'b0;
               busy       <= 1'b0;
               r_state    <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: doc/listener_fsm.md
Name: listener_fsm

Overview:
Receiving end of the 4-phase req/ack handshake driven by the talker FSM in the sending clock domain.
- Synchronises the incoming request and captures the data word the talker holds stable while req is high.
- Presents the word to a local consumer with a valid/ready handshake.
- Returns ack only after the consumer accepts the word, so the talker cannot overwrite unconsumed data.

Parameters:
DATA_WIDTH, 8, width of the transferred data word
SYNC_STAGES, 2, flip-flops in the req_in synchroniser (legal range 2..4)
CNT_WIDTH, 16, width of the completed-transfer counter

Ports:
clk  input  1  receiving-domain clock
reset  input  1  synchronous, active-high reset
req_in  input  1  request from talker, asynchronous to clk
data_in  input  DATA_WIDTH  talker data; stable from req_in rise until ack_out is seen high
ack_out  output  1  acknowledge to talker, registered, glitch-free
data_out  output  DATA_WIDTH  captured word
data_valid  output  1  data_out holds an unconsumed word
data_ready  input  1  consumer accepts data_out when data_valid && data_ready
busy  output  1  high in any state other than IDLE
xfer_count  output  CNT_WIDTH  number of completed transfers

Behaviour:
- Synchroniser: SYNC_STAGES flops clocked by clk, all cleared by reset. req_s is the last stage output. The FSM uses only req_s.
- All outputs are registered and decoded from the state register, with no combinational path from any input to any output.
- Reset values: state IDLE, ack_out=0, data_valid=0, busy=0, data_out=0, xfer_count=0, synchroniser=0.
- State IDLE:
  - ack_out=0, data_valid=0.
  - If req_s=1: load data_out<=data_in and go to HOLD.
- State HOLD:
  - data_valid=1, ack_out=0.
  - If data_ready=1: go to ACK. data_valid drops on the same edge.
  - If data_ready=0: stay in HOLD with data_out frozen, indefinitely.
- State ACK:
  - ack_out=1, data_valid=0.
  - If req_s=0: go to IDLE, ack_out drops, xfer_count increments on that edge.
  - If req_s=1: stay in ACK.
- Latency:
  - req_in rise sampled at edge 0 gives req_s=1 after SYNC_STAGES edges.
  - data_valid=1 one edge later, i.e. edge SYNC_STAGES+1.
  - With data_ready tied high, ack_out=1 at edge SYNC_STAGES+2.
  - req_in fall to ack_out fall is SYNC_STAGES+1 edges.
- data_in is sampled only on the IDLE->HOLD edge. Changes on data_in at any other time have no effect.
- Back-to-back transfers: IDLE is re-entered only with req_s=0, so one req pulse yields exactly one capture. A new request is recognised on the first cycle req_s=1 in IDLE.
- data_ready asserted while data_valid=0 is ignored.
- xfer_count wraps from 2^CNT_WIDTH-1 to 0 with no flag.
- Reset mid-operation: returns to the reset state on the next edge and any held word is discarded. If the talker still holds req_in=1 after reset is released, this is treated as a new request and data_in is recaptured. Correct operation relies on the talker also resetting.
- Simultaneous reset and any other event: reset wins.
- Glitch/metastability: only the synchroniser flops see req_in. data_in is never synchronised; its stability is guaranteed by the protocol.

Decomposition:
- Shared handshake package holds:
  - the state encoding, a 2-bit enum IDLE=0, HOLD=1, ACK=2;
  - default SYNC_STAGES, shared with the talker's ack synchroniser.
- One natural sub-module is sync_nff: a parameterised N-stage single-bit synchroniser with synchronous reset. It is instantiated here for req_in and reused by the talker for ack.

Test Plan:
- Reset then idle: reset=1 for 3 cycles, req_in=0 -> ack_out=0, data_valid=0, busy=0, data_out=0x00, xfer_count=0 throughout.
- Single transfer, data_ready=1: data_in=0xA5, raise req_in -> data_valid=1 with data_out=0xA5 at edge 3, ack_out=1 at edge 4. Drop req_in -> ack_out=0 three edges later, xfer_count=1.
- Backpressure: data_in=0x3C, data_ready=0 for 10 cycles -> data_valid stays 1, ack_out stays 0, data_out=0x3C. Change data_in to 0xFF during the stall -> data_out stays 0x3C. Raise data_ready -> ack_out=1 next edge.
- Four back-to-back transfers from a talker model (0x01, 0x02, 0x03, 0x04) with random data_ready stalls -> consumer receives exactly 0x01..0x04 in order, xfer_count=4, no duplicate captures.
- Reset mid-transfer: assert reset while in HOLD with req_in held high -> data_valid=0, ack_out=0 the next edge. After release, the word is recaptured and the transfer completes with xfer_count=1.
- Counter wrap (CNT_WIDTH=2): run 5 transfers -> xfer_count sequence 1, 2, 3, 0, 1.
